// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator with at most one outstanding transfer.
// A command is accepted in IDLE. It is issued as a single strobe that holds
// through stall, and it completes on ack or on a bus timeout. Each completion
// produces a one-cycle response pulse. Its data and error flag are held until
// the next response.
module wb_initiator #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    input  logic                  cmd_we_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  wb_we_o,
    output logic                  wb_cycle_o,
    output logic                  wb_strobe_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    // The counter holds the number of cycle-high edges already seen.
    // The cycle is aborted on the edge where it equals TIMEOUT_CYCLES-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]           cnt_q, cnt_d;

    // State and bus registers; reset clears everything immediately, which also aborts a live cycle
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: ack has priority over timeout, and timeout has priority over strobe acceptance
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cyc_q ? (cnt_q + 16'd1) : cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_data_i;
                    we_d    = cmd_we_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT_ACK: begin
                if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? '0 : wb_data_i;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_IDLE;
                end else if (state_q == ST_REQ && !wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_we_o     = we_q;
    assign wb_cycle_o  = cyc_q;
    assign wb_strobe_o = stb_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a programmable responder, a bus monitor, directed vectors,
// randomized transfers against a transfer-level model, and multi-cycle corner sequences.
module tb_wb_initiator;

    localparam int TMO = 8;

    logic        wb_clock_i;
    logic        wb_reset_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [16:0] cmd_addr_i;
    logic [7:0]  cmd_data_i;
    logic        cmd_we_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic [16:0] wb_addr_o;
    logic [7:0]  wb_data_o;
    logic [7:0]  wb_data_i;
    logic        wb_we_o;
    logic        wb_cycle_o;
    logic        wb_strobe_o;
    logic        wb_stall_i;
    logic        wb_ack_i;

    wb_initiator #(.DATA_WIDTH(8), .ADDR_WIDTH(17), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clock_i  (wb_clock_i),
        .wb_reset_n_i(wb_reset_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_we_i    (cmd_we_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_we_o     (wb_we_o),
        .wb_cycle_o  (wb_cycle_o),
        .wb_strobe_o (wb_strobe_o),
        .wb_stall_i  (wb_stall_i),
        .wb_ack_i    (wb_ack_i)
    );

    initial wb_clock_i = 1'b0;
    always #5 wb_clock_i = ~wb_clock_i;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  wdata;
        bit          we;
        int          stall;
        int          delay;
        bit          no_ack;
        logic [7:0]  rdata;
        logic [7:0]  exp_data;
        bit          exp_err;
        int          exp_cyc;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        int          cyc;
        int          stb;
        bit          stable;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic        we;
    } rsp_t;

    rsp_t rsp_q[$];
    int   n_checks;
    int   n_errors;

    // Responder configuration
    int         cfg_stall;
    int         cfg_delay;
    bit         cfg_no_ack;
    logic [7:0] cfg_rdata;
    bit         cfg_rd_addr;
    bit         stray_ack;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: edge index k counts cycle-high edges; stall for the first cfg_stall, ack cfg_delay edges after acceptance
    initial begin
        int k;
        k = 0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_data_i  = 8'h00;
        forever begin
            @(negedge wb_clock_i);
            if (!wb_reset_n_i || !wb_cycle_o) begin
                k          = 0;
                wb_stall_i = 1'b0;
                wb_ack_i   = stray_ack;
                wb_data_i  = cfg_rdata;
            end else begin
                wb_stall_i = (k < cfg_stall);
                wb_ack_i   = !cfg_no_ack && (k == cfg_stall + cfg_delay);
                wb_data_i  = cfg_rd_addr ? wb_addr_o[7:0] : cfg_rdata;
                k++;
            end
        end
    end

    // Monitor: counts cycle/strobe-high cycles, checks request stability, records each response
    initial begin
        int          cur_cyc;
        int          cur_stb;
        bit          stable;
        logic [16:0] ca;
        logic [7:0]  cd;
        logic        cw;
        rsp_t        r;
        cur_cyc = 0; cur_stb = 0; stable = 1'b1; ca = '0; cd = '0; cw = 1'b0;
        forever begin
            @(negedge wb_clock_i);
            if (!wb_reset_n_i) begin
                cur_cyc = 0; cur_stb = 0; stable = 1'b1;
            end else begin
                if (wb_cycle_o) begin
                    if (cur_cyc == 0) begin
                        ca = wb_addr_o; cd = wb_data_o; cw = wb_we_o;
                    end else if (wb_addr_o != ca || wb_data_o != cd || wb_we_o != cw) begin
                        stable = 1'b0;
                    end
                    cur_cyc++;
                    if (wb_strobe_o) cur_stb++;
                end
                if (rsp_valid_o) begin
                    r.data = rsp_data_o; r.err = rsp_err_o; r.cyc = cur_cyc; r.stb = cur_stb;
                    r.stable = stable; r.addr = ca; r.wdata = cd; r.we = cw;
                    rsp_q.push_back(r);
                    cur_cyc = 0; cur_stb = 0; stable = 1'b1;
                end
            end
        end
    end

    function automatic vec_t mk(input logic [16:0] a, input logic [7:0] wd, input bit we,
                                input int s, input int d, input bit na, input logic [7:0] rd,
                                input logic [7:0] ed, input bit ee, input int ec, input int es);
        vec_t v;
        v.addr = a; v.wdata = wd; v.we = we; v.stall = s; v.delay = d; v.no_ack = na;
        v.rdata = rd; v.exp_data = ed; v.exp_err = ee; v.exp_cyc = ec; v.exp_stb = es;
        return v;
    endfunction

    // Transfer-level model. The ack lands on edge stall+delay of the cycle.
    // It completes normally if that edge is within the TMO-edge budget.
    // Otherwise the cycle is cut at TMO edges with an error.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   ack_at;
        r = v;
        ack_at = v.stall + v.delay;
        if (!v.no_ack && ack_at <= TMO - 1) begin
            r.exp_err  = 1'b0;
            r.exp_data = v.we ? 8'h00 : v.rdata;
            r.exp_cyc  = ack_at + 1;
        end else begin
            r.exp_err  = 1'b1;
            r.exp_data = 8'h00;
            r.exp_cyc  = TMO;
        end
        r.exp_stb = (v.stall + 1 < r.exp_cyc) ? v.stall + 1 : r.exp_cyc;
        return r;
    endfunction

    task automatic do_cmd(input logic [16:0] a, input logic [7:0] d, input bit w, output bit ok);
        int n;
        n = 0;
        @(negedge wb_clock_i);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_data_i = d; cmd_we_i = w;
        while (!cmd_ready_o && n < 50) begin
            @(negedge wb_clock_i);
            n++;
        end
        ok = cmd_ready_o;
        @(posedge wb_clock_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        rsp_t r;
        bit   ok;
        int   n;
        cfg_stall = v.stall; cfg_delay = v.delay; cfg_no_ack = v.no_ack; cfg_rdata = v.rdata;
        do_cmd(v.addr, v.wdata, v.we, ok);
        chk({tag, ".accept"}, ok, 1);
        n = 0;
        while (rsp_q.size() == 0 && n < 60) begin
            @(negedge wb_clock_i);
            n++;
        end
        chk({tag, ".rsp_seen"}, rsp_q.size() != 0, 1);
        if (rsp_q.size() == 0) return;
        r = rsp_q.pop_front();
        chk({tag, ".data"}, r.data, v.exp_data);
        chk({tag, ".err"}, r.err, v.exp_err);
        chk({tag, ".cyc_cycles"}, r.cyc, v.exp_cyc);
        chk({tag, ".stb_cycles"}, r.stb, v.exp_stb);
        chk({tag, ".stable"}, r.stable, 1);
        chk({tag, ".bus_addr"}, r.addr, v.addr);
        chk({tag, ".bus_we"}, r.we, v.we);
        chk({tag, ".bus_wdata"}, r.wdata, v.wdata);
        repeat (2) @(negedge wb_clock_i);
        chk({tag, ".single_pulse"}, rsp_q.size(), 0);
        chk({tag, ".hold_data"}, rsp_data_o, v.exp_data);
        chk({tag, ".hold_err"}, rsp_err_o, v.exp_err);
        chk({tag, ".ready_after"}, cmd_ready_o, 1);
        rsp_q.delete();
        $display("txn %s addr=%05h we=%0d stall=%0d delay=%0d noack=%0d -> data=%02h err=%0d cyc=%0d stb=%0d",
                 tag, v.addr, v.we, v.stall, v.delay, v.no_ack, r.data, r.err, r.cyc, r.stb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        dir_tbl[8];
        vec_t        v;
        rsp_t        r;
        bit          ok;
        int          n;
        int          qn;
        logic [16:0] a1;
        logic [16:0] a2;

        n_checks = 0; n_errors = 0;
        cfg_stall = 0; cfg_delay = 1; cfg_no_ack = 1'b0; cfg_rdata = 8'h00;
        cfg_rd_addr = 1'b0; stray_ack = 1'b0;
        cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0; cmd_we_i = 1'b0;

        dir_tbl[0] = mk(17'h1ABCD, 8'h00, 1'b0, 0,  3, 1'b0, 8'h5A, 8'h5A, 1'b0, 4, 1);
        dir_tbl[1] = mk(17'h00010, 8'hC3, 1'b1, 4,  1, 1'b0, 8'hA5, 8'h00, 1'b0, 6, 5);
        dir_tbl[2] = mk(17'h0F0F0, 8'h11, 1'b0, 0,  1, 1'b1, 8'h99, 8'h00, 1'b1, 8, 1);
        dir_tbl[3] = mk(17'h12345, 8'h22, 1'b0, 0,  7, 1'b0, 8'h77, 8'h77, 1'b0, 8, 1);
        dir_tbl[4] = mk(17'h00001, 8'h33, 1'b0, 0,  8, 1'b0, 8'h44, 8'h00, 1'b1, 8, 1);
        dir_tbl[5] = mk(17'h1FFFF, 8'hFF, 1'b1, 10, 1, 1'b0, 8'h00, 8'h00, 1'b1, 8, 8);
        dir_tbl[6] = mk(17'h0AAAA, 8'h55, 1'b0, 2,  5, 1'b0, 8'hE1, 8'hE1, 1'b0, 8, 3);
        dir_tbl[7] = mk(17'h15555, 8'h66, 1'b1, 3,  4, 1'b0, 8'hBB, 8'h00, 1'b0, 8, 4);

        // Reset is applied between clock edges and must take effect immediately
        wb_reset_n_i = 1'b1;
        #2 wb_reset_n_i = 1'b0;
        #1;
        chk("reset.cyc", wb_cycle_o, 0);
        chk("reset.stb", wb_strobe_o, 0);
        chk("reset.we", wb_we_o, 0);
        chk("reset.rsp_valid", rsp_valid_o, 0);
        chk("reset.rsp_err", rsp_err_o, 0);
        chk("reset.rsp_data", rsp_data_o, 0);
        chk("reset.addr", wb_addr_o, 0);
        chk("reset.wdata", wb_data_o, 0);
        chk("reset.ready", cmd_ready_o, 1);
        repeat (3) @(negedge wb_clock_i);

        // The first command is taken on the first edge after release
        wb_reset_n_i = 1'b1;
        cfg_stall = 0; cfg_delay = 1; cfg_no_ack = 1'b0; cfg_rdata = 8'h3C;
        cmd_valid_i = 1'b1; cmd_addr_i = 17'h00ABC; cmd_data_i = 8'h00; cmd_we_i = 1'b0;
        @(posedge wb_clock_i);
        #1;
        cmd_valid_i = 1'b0;
        chk("first.cyc", wb_cycle_o, 1);
        chk("first.stb", wb_strobe_o, 1);
        chk("first.addr", wb_addr_o, 17'h00ABC);
        n = 0;
        while (rsp_q.size() == 0 && n < 40) begin
            @(negedge wb_clock_i);
            n++;
        end
        chk("first.rsp_seen", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("first.data", r.data, 8'h3C);
            chk("first.err", r.err, 0);
        end
        $display("txn first addr=00abc we=0 -> data=%02h err=%0d", rsp_data_o, rsp_err_o);
        rsp_q.delete();

        for (int i = 0; i < 8; i++) begin
            run_vec(dir_tbl[i], $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            v.addr   = 17'($urandom);
            v.wdata  = 8'($urandom);
            v.we     = 1'($urandom);
            v.stall  = int'($urandom_range(0, 4));
            v.delay  = int'($urandom_range(1, 8));
            v.no_ack = ($urandom_range(0, 7) == 0);
            v.rdata  = 8'($urandom);
            v        = predict(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Back-to-back reads with cmd_valid held: one idle bus cycle, responses in order
        a1 = 17'h10042;
        a2 = 17'h00099;
        cfg_stall = 0; cfg_delay = 2; cfg_no_ack = 1'b0; cfg_rd_addr = 1'b1;
        qn = rsp_q.size();
        @(negedge wb_clock_i);
        cmd_valid_i = 1'b1; cmd_addr_i = a1; cmd_data_i = 8'h00; cmd_we_i = 1'b0;
        n = 0;
        while (!cmd_ready_o && n < 20) begin
            @(negedge wb_clock_i);
            n++;
        end
        @(posedge wb_clock_i);
        #1;
        cmd_addr_i = a2;
        n = 0;
        do begin
            @(negedge wb_clock_i);
            n++;
        end while (!rsp_valid_o && n < 30);
        chk("b2b.rsp1_seen", rsp_valid_o, 1);
        chk("b2b.ready_in_rsp", cmd_ready_o, 1);
        chk("b2b.idle_gap", wb_cycle_o, 0);
        @(negedge wb_clock_i);
        chk("b2b.stb2", wb_strobe_o, 1);
        chk("b2b.addr2", wb_addr_o, a2);
        cmd_valid_i = 1'b0;
        n = 0;
        while (rsp_q.size() < qn + 2 && n < 40) begin
            @(negedge wb_clock_i);
            n++;
        end
        chk("b2b.count", rsp_q.size(), qn + 2);
        if (rsp_q.size() >= 2) begin
            r = rsp_q.pop_front();
            chk("b2b.data1", r.data, a1[7:0]);
            $display("txn b2b1 addr=%05h -> data=%02h err=%0d", a1, r.data, r.err);
            r = rsp_q.pop_front();
            chk("b2b.data2", r.data, a2[7:0]);
            $display("txn b2b2 addr=%05h -> data=%02h err=%0d", a2, r.data, r.err);
        end
        rsp_q.delete();
        cfg_rd_addr = 1'b0;

        // Reset during WAIT_ACK aborts silently; stray acks after release are ignored
        cfg_stall = 0; cfg_delay = 30; cfg_no_ack = 1'b0;
        qn = rsp_q.size();
        do_cmd(17'h0BEEF, 8'h12, 1'b0, ok);
        chk("rst.accept", ok, 1);
        repeat (2) @(negedge wb_clock_i);
        chk("rst.pre_cyc", wb_cycle_o, 1);
        chk("rst.pre_stb", wb_strobe_o, 0);
        #2 wb_reset_n_i = 1'b0;
        #1;
        chk("rst.cyc_async", wb_cycle_o, 0);
        chk("rst.stb_async", wb_strobe_o, 0);
        chk("rst.addr_async", wb_addr_o, 0);
        chk("rst.ready_async", cmd_ready_o, 1);
        repeat (2) @(negedge wb_clock_i);
        wb_reset_n_i = 1'b1;
        stray_ack = 1'b1;
        repeat (5) @(negedge wb_clock_i);
        stray_ack = 1'b0;
        @(negedge wb_clock_i);
        chk("rst.no_rsp", rsp_q.size(), qn);
        chk("rst.cyc_after", wb_cycle_o, 0);
        $display("txn reset_abort addr=0beef -> responses=%0d", rsp_q.size() - qn);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the Wishbone data bus width.
REQ-002 Parameter ADDR_WIDTH, default 17, SHALL set the Wishbone address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum number of cycles with wb_cycle_o high before an aborted cycle; range 2..65535.
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-005 Ports SHALL be:
- wb_clock_i  in  1  clock
- wb_reset_n_i  in  1  async active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_addr_i  in  ADDR_WIDTH  command address
- cmd_data_i  in  DATA_WIDTH  write data
- cmd_we_i  in  1  1=write, 0=read
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  DATA_WIDTH  read data
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o
- wb_addr_o  out  ADDR_WIDTH  Wishbone B4 address
- wb_data_o  out  DATA_WIDTH  Wishbone write data
- wb_data_i  in  DATA_WIDTH  Wishbone read data
- wb_we_o  out  1  Wishbone write enable
- wb_cycle_o  out  1  Wishbone CYC
- wb_strobe_o  out  1  Wishbone STB
- wb_stall_i  in  1  Wishbone STALL (pipelined)
- wb_ack_i  in  1  Wishbone ACK

Function
REQ-006 The block SHALL be a Wishbone B4 pipelined initiator with at most one outstanding transfer.
REQ-007 States SHALL be IDLE, REQ and WAIT_ACK.
REQ-008 cmd_ready_o SHALL be high if and only if state is IDLE; it is combinational from state only.
REQ-009 IDLE with cmd_valid_i high at an edge: the block SHALL latch addr, data and we into wb_addr_o, wb_data_o and wb_we_o, set wb_cycle_o and wb_strobe_o to 1, clear the timeout counter, and go to REQ.
REQ-010 REQ: at an edge where wb_stall_i is 0, the block SHALL deassert wb_strobe_o at that edge and go to WAIT_ACK; while wb_stall_i is 1, wb_strobe_o and the address, data and we outputs SHALL hold.
REQ-011 At an edge in REQ or WAIT_ACK with wb_ack_i high: wb_cycle_o and wb_strobe_o SHALL go to 0, rsp_valid_o SHALL go to 1 for exactly one cycle, and rsp_err_o SHALL go to 0.
REQ-012 On that same ack edge, rsp_data_o SHALL be wb_data_i if wb_we_o is 0, and 0 if it is a write; the state SHALL return to IDLE.
REQ-013 The timeout counter SHALL increment every cycle that wb_cycle_o is high. When it reaches TIMEOUT_CYCLES-1 with no ack on that edge, the block SHALL drop cycle and strobe, pulse rsp_valid_o with rsp_err_o=1 and rsp_data_o=0, and return to IDLE.
REQ-014 If ack and timeout occur on the same edge, ack SHALL win and rsp_err_o SHALL be 0.
REQ-015 wb_ack_i SHALL be ignored while wb_cycle_o is 0, so that stray acks produce no response.
REQ-016 rsp_data_o and rsp_err_o SHALL hold their values until the next response.
REQ-017 A new command SHALL be acceptable in the cycle in which rsp_valid_o is high, giving back-to-back transfers with one idle bus cycle between them.
REQ-018 wb_addr_o, wb_data_o and wb_we_o SHALL remain stable from strobe assertion until the cycle ends.

Reset
REQ-019 While wb_reset_n_i is low, the following SHALL be forced immediately, regardless of the clock: state=IDLE, wb_cycle_o=0, wb_strobe_o=0, wb_we_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, wb_addr_o=0, wb_data_o=0, counter=0.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer with no response pulse; an ack arriving after reset SHALL be ignored per REQ-015.
REQ-021 Deassertion of wb_reset_n_i SHALL be synchronised by the integrator. The first command SHALL be accepted on the first edge after release.

Verification
REQ-022 Read, no stall: cmd addr=0x1ABCD, we=0; responder returns stall=0 and ack 3 cycles after STB accepted with data 0x5A -> strobe high exactly 1 cycle; rsp_valid_o pulses once; rsp_data_o=0x5A; rsp_err_o=0.
REQ-023 Write with stall: cmd addr=0x00010, data=0xC3, we=1; stall held high 4 cycles -> strobe high 5 cycles; addr and data stable throughout; after ack, rsp_data_o=0x00 and rsp_err_o=0.
REQ-024 Timeout: TIMEOUT_CYCLES=8, responder never acks -> cycle high exactly 8 cycles; rsp_valid_o pulse with rsp_err_o=1 and rsp_data_o=0; cmd_ready_o high afterwards.
REQ-025 Ack and timeout on the same edge: TIMEOUT_CYCLES=8, ack on the 8th cycle with data 0x77 -> rsp_err_o=0 and rsp_data_o=0x77.
REQ-026 Reset mid-transfer: drive wb_reset_n_i low during WAIT_ACK, then an ack arrives after release -> cycle and strobe drop asynchronously; no rsp_valid_o pulse is produced.
REQ-027 Back-to-back: two reads issued with cmd_valid_i held high -> the second STB asserts on the edge after the first rsp_valid_o; two responses are produced, in order.
